bin_clock_core: RTL and testbench

Parametrised second-generation binary clock core. It keeps seconds, minutes and hours with a configurable 1 Hz prescaler and a runtime 12/24-hour display mode. Per-field set buttons are synchronised and debounced, and a held button auto-repeats. It drops in under the Tiny Tapeout top wrapper in place of the first-generation clock, driving LED banks directly from its binary outputs.

---
 rtl/bin_clock_core_if.sv | 26 ++
 rtl/bin_clock_core.sv | 149 ++++++++++++++
 tb/tb_bin_clock_core.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_clock_core_if.sv
// Pin bundle of the binary clock core: control/button inputs and LED-bank outputs.
// Master drives the controls and buttons, slave is the clock core.
// No handshake: inputs are levels sampled every cycle, outputs are live levels.
interface bin_clock_core_if;
    logic       time_set;
    logic       id_switch;
    logic       hour_id;
    logic       minute_id;
    logic       seconds_id;
    logic       mode_24h;
    logic [4:0] hour_out;
    logic       meridiem_out;
    logic [5:0] minute_out;
    logic [5:0] seconds_out;
    logic       sec_pulse_o;

    modport master (
        output time_set, id_switch, hour_id, minute_id, seconds_id, mode_24h,
        input  hour_out, meridiem_out, minute_out, seconds_out, sec_pulse_o
    );

    modport slave (
        input  time_set, id_switch, hour_id, minute_id, seconds_id, mode_24h,
        output hour_out, meridiem_out, minute_out, seconds_out, sec_pulse_o
    );
endinterface

// File: rtl/bin_clock_core.sv
// Binary h:m:s clock with 1 Hz prescaler, 12/24h display and debounced, auto-repeating set buttons.
// Latency: tick visible 1 cycle after prescaler wrap; button step visible DEBOUNCE_CYCLES+3 edges after press.
// No backpressure: buttons are free-running levels, steps outside set mode are dropped.
module bin_clock_core #(
    parameter int TICKS_PER_SEC   = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int REPEAT_CYCLES   = 2_500_000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    bin_clock_core_if.slave  bus
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [PW-1:0] presc;
    logic [4:0]    hour24;
    logic [5:0]    minute_q;
    logic [5:0]    second_q;
    logic          pulse_q;

    // bit 0 = seconds, bit 1 = minutes, bit 2 = hours
    logic [2:0] btn_raw;
    logic [2:0] step;

    assign btn_raw = {bus.hour_id, bus.minute_id, bus.seconds_id};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic          s1;
        logic          s2;
        logic          lvl;
        logic          lvl_d;
        logic [DW-1:0] dcnt;
        logic          rise;
        logic          rep_fire;

        assign rise = lvl & ~lvl_d;

        // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                lvl   <= 1'b0;
                lvl_d <= 1'b0;
                dcnt  <= '0;
            end else begin
                s1    <= btn_raw[i];
                s2    <= s1;
                lvl_d <= lvl;
                if (s2 != lvl) begin
                    if (dcnt == DEB_LAST) begin
                        lvl  <= s2;
                        dcnt <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end else begin
                    dcnt <= '0;
                end
            end
        end

        if (REPEAT_CYCLES > 0) begin : g_rep
            logic [RW-1:0] rcnt;

            // Phase is anchored to the press step; releasing clears it at once.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    rcnt <= '0;
                end else if (!lvl || rise || rcnt == REP_LAST) begin
                    rcnt <= '0;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end

            assign rep_fire = lvl & lvl_d & (rcnt == REP_LAST);
        end else begin : g_norep
            assign rep_fire = 1'b0;
        end

        assign step[i] = rise | rep_fire;
    end

    function automatic logic [5:0] wrap60(input logic [5:0] v, input logic up);
        if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    function automatic logic [4:0] wrap24(input logic [4:0] v, input logic up);
        if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
        else    return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc    <= '0;
            hour24   <= '0;
            minute_q <= '0;
            second_q <= '0;
            pulse_q  <= 1'b0;
        end else if (bus.time_set) begin
            // Frozen time; each field steps independently, no carries.
            presc   <= '0;
            pulse_q <= 1'b0;
            if (step[0]) second_q <= wrap60(second_q, bus.id_switch);
            if (step[1]) minute_q <= wrap60(minute_q, bus.id_switch);
            if (step[2]) hour24   <= wrap24(hour24, bus.id_switch);
        end else if (presc == PRE_LAST) begin
            presc   <= '0;
            pulse_q <= 1'b1;
            if (second_q == 6'd59) begin
                second_q <= 6'd0;
                if (minute_q == 6'd59) begin
                    minute_q <= 6'd0;
                    hour24   <= wrap24(hour24, 1'b1);
                end else begin
                    minute_q <= minute_q + 6'd1;
                end
            end else begin
                second_q <= second_q + 6'd1;
            end
        end else begin
            presc   <= presc + 1'b1;
            pulse_q <= 1'b0;
        end
    end

    logic [4:0] hour12;

    always_comb begin
        hour12 = (hour24 >= 5'd12) ? hour24 - 5'd12 : hour24;
        if (hour12 == 5'd0) hour12 = 5'd12;
    end

    assign bus.hour_out     = bus.mode_24h ? hour24 : hour12;
    assign bus.meridiem_out = ~bus.mode_24h & (hour24 >= 5'd12);
    assign bus.minute_out   = minute_q;
    assign bus.seconds_out  = second_q;
    assign bus.sec_pulse_o  = pulse_q;

endmodule

// File: tb/tb_bin_clock_core.sv
// Directed + randomized bench for bin_clock_core against a seconds-of-day reference model.
module tb_bin_clock_core;

    localparam int T = 4;
    localparam int D = 2;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bin_clock_core_if bus();

    bin_clock_core #(
        .TICKS_PER_SEC  (T),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    // Reference model: time of day as a plain second count.
    int tod;
    int phase;
    int exp_pulse;
    int pulses;
    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int f_hour();
        return tod / 3600;
    endfunction

    function automatic int f_min();
        return (tod / 60) % 60;
    endfunction

    function automatic int f_sec();
        return tod % 60;
    endfunction

    function automatic int field(input int f);
        case (f)
            0:       return f_sec();
            1:       return f_min();
            default: return f_hour();
        endcase
    endfunction

    task automatic check_time(input string tag);
        int h;
        h = f_hour();
        if (bus.mode_24h) begin
            chk({tag, ".hour"}, 32'(bus.hour_out), h);
            chk({tag, ".ampm"}, 32'(bus.meridiem_out), 0);
        end else begin
            chk({tag, ".hour"}, 32'(bus.hour_out), (h % 12 == 0) ? 12 : h % 12);
            chk({tag, ".ampm"}, 32'(bus.meridiem_out), (h >= 12) ? 1 : 0);
        end
        chk({tag, ".min"}, 32'(bus.minute_out), f_min());
        chk({tag, ".sec"}, 32'(bus.seconds_out), f_sec());
    endtask

    // One clock edge, then advance the model and check the seconds pulse.
    task automatic cyc();
        @(posedge clk);
        #1;
        exp_pulse = 0;
        if (rst || bus.time_set) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == T) begin
                phase     = 0;
                tod       = (tod + 1) % 86400;
                exp_pulse = 1;
            end
        end
        if (bus.sec_pulse_o === 1'b1) pulses++;
        chk("sec_pulse", 32'(bus.sec_pulse_o), exp_pulse);
    endtask

    task automatic apply_step(input int f, input bit up);
        int h, m, s, d;
        h = f_hour(); m = f_min(); s = f_sec();
        d = up ? 1 : -1;
        case (f)
            0:       s = (s + d + 60) % 60;
            1:       m = (m + d + 60) % 60;
            default: h = (h + d + 24) % 24;
        endcase
        tod = h * 3600 + m * 60 + s;
    endtask

    task automatic drive_btns(input logic [2:0] v);
        bus.seconds_id = v[0];
        bus.minute_id  = v[1];
        bus.hour_id    = v[2];
    endtask

    // Clean press: held 5 cycles, step due at the 5th edge, then settle with no repeat.
    task automatic press(input logic [2:0] mask, input bit up);
        bus.id_switch = up;
        drive_btns(mask);
        repeat (4) cyc();
        check_time("before_step");
        cyc();
        if (bus.time_set) begin
            for (int f = 0; f < 3; f++)
                if (mask[f]) apply_step(f, up);
        end
        check_time("at_step");
        drive_btns(3'b000);
        repeat (8) cyc();
        check_time("settled");
    endtask

    task automatic set_field(input int f, input int target);
        int modulus, fwd, guard;
        modulus = (f == 2) ? 24 : 60;
        guard   = 0;
        while (field(f) != target && guard < 40) begin
            fwd = (target - field(f) + modulus) % modulus;
            press(3'(1 << f), fwd <= modulus / 2);
            guard++;
        end
        chk("set_field", 32'(field(f)), target);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".hour"}, 32'(bus.hour_out), bus.mode_24h ? 0 : 12);
        chk({tag, ".ampm"}, 32'(bus.meridiem_out), 0);
        chk({tag, ".min"}, 32'(bus.minute_out), 0);
        chk({tag, ".sec"}, 32'(bus.seconds_out), 0);
        chk({tag, ".pulse"}, 32'(bus.sec_pulse_o), 0);
    endtask

    initial begin
        int s0, th, tm, ts, runlen;
        total = 0; bad = 0; pulses = 0;
        tod = 0; phase = 0; exp_pulse = 0;
        rst = 1'b1;
        bus.time_set = 1'b0; bus.id_switch = 1'b0; bus.mode_24h = 1'b0;
        drive_btns(3'b000);

        // Reset values in both display modes
        #3;
        check_reset_outputs("reset12");
        bus.mode_24h = 1'b1;
        #1;
        check_reset_outputs("reset24");
        bus.mode_24h = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;

        // 240 cycles of free run: one minute, 60 single-cycle pulses
        pulses = 0;
        repeat (240) cyc();
        chk("pulse_count", pulses, 60);
        chk("run240.min", 32'(bus.minute_out), 1);
        chk("run240.sec", 32'(bus.seconds_out), 0);
        check_time("run240");

        // Preload 23:59:59, release, one tick later full wrap
        bus.time_set = 1'b1;
        cyc();
        set_field(2, 23);
        set_field(1, 59);
        set_field(0, 59);
        check_time("preload");
        bus.time_set = 1'b0;
        repeat (3) cyc();
        check_time("pre_wrap");
        cyc();
        chk("wrap12.hour", 32'(bus.hour_out), 12);
        chk("wrap12.ampm", 32'(bus.meridiem_out), 0);
        check_time("wrap12");
        bus.mode_24h = 1'b1;
        #1;
        chk("wrap24.hour", 32'(bus.hour_out), 0);
        check_time("wrap24");
        bus.mode_24h = 1'b0;

        // Minute decrement from 0, then a glitch on hour_id
        bus.time_set = 1'b1;
        cyc();
        set_field(1, 0);
        th = f_hour();
        press(3'b010, 1'b0);
        chk("min_dec", 32'(bus.minute_out), 59);
        chk("min_dec.hour24", f_hour(), th);
        bus.id_switch = 1'b1;
        bus.hour_id = 1'b1;
        cyc();
        bus.hour_id = 1'b0;
        repeat (10) cyc();
        check_time("glitch");

        // 11 AM stepped up becomes 12 PM; 24h view shows 12
        set_field(2, 11);
        press(3'b100, 1'b1);
        chk("noon12.hour", 32'(bus.hour_out), 12);
        chk("noon12.ampm", 32'(bus.meridiem_out), 1);
        bus.mode_24h = 1'b1;
        #1;
        chk("noon24.hour", 32'(bus.hour_out), 12);
        chk("noon24.ampm", 32'(bus.meridiem_out), 0);
        bus.mode_24h = 1'b0;

        // Held seconds button: press step at +5, repeats at +13, +21, +29
        set_field(0, 0);
        s0 = f_sec();
        bus.id_switch = 1'b1;
        bus.seconds_id = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            cyc();
            if (t == 5 || t == 13 || t == 21 || t == 29) apply_step(0, 1'b1);
            if (t == 30) bus.seconds_id = 1'b0;
            chk("hold.sec", 32'(bus.seconds_out), f_sec());
        end
        chk("hold.total", 32'(bus.seconds_out), s0 + 4);

        // All three buttons in the same cycle
        press(3'b111, 1'b1);

        // Random preloads and run lengths
        for (int it = 0; it < 3; it++) begin
            th = $urandom_range(0, 23);
            tm = $urandom_range(0, 59);
            ts = $urandom_range(0, 59);
            bus.mode_24h = 1'($urandom_range(0, 1));
            bus.time_set = 1'b1;
            cyc();
            set_field(2, th);
            set_field(1, tm);
            set_field(0, ts);
            bus.time_set = 1'b0;
            runlen = $urandom_range(10, 300);
            repeat (runlen) cyc();
            check_time("random_run");
        end
        bus.mode_24h = 1'b0;

        // Run mode: a press must not touch the time
        bus.time_set = 1'b0;
        press(3'b100, 1'b1);

        // Reset during debounce clears everything at once
        bus.hour_id = 1'b1;
        repeat (3) cyc();
        #2;
        rst = 1'b1;
        #1;
        tod = 0; phase = 0;
        check_reset_outputs("async_reset");
        bus.hour_id = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (20) cyc();
        check_time("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
